sync_reset_timer: RTL and testbench



---
 rtl/sync_reset_timer_if.sv | 21 ++
 rtl/sync_reset_timer.sv | 46 ++++
 tb/tb_sync_reset_timer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sync_reset_timer_if.sv
// Output bundle of the reset stretcher: the stretched reset and its cycle counter.
interface sync_reset_timer_if #(
    parameter int unsigned LENGTH = 7
);
    localparam int unsigned CountW = $clog2(LENGTH + 1);

    logic              reset_out;
    logic [CountW-1:0] count;

    // Timer drives the bundle
    modport master (
        output reset_out,
        output count
    );

    // Downstream logic observes the bundle
    modport slave (
        input reset_out,
        input count
    );
endinterface

// File: rtl/sync_reset_timer.sv
// Reset stretcher: asserts reset_out asynchronously whenever reset_in is low and after power-up,
// then holds it for LENGTH rising clk edges before releasing it synchronously.
module sync_reset_timer #(
    parameter int unsigned LENGTH = 7
) (
    input  logic                clk,
    input  logic                reset_in,
    sync_reset_timer_if.master  bus
);
    localparam int unsigned CountW = $clog2(LENGTH + 1);
    localparam logic [CountW-1:0] CountMax  = CountW'(LENGTH);
    localparam logic [CountW-1:0] CountLast = CountW'(LENGTH - 1);

    // Power-up values come from the initialisers, so reset_out is high at time 0 without
    // needing any reset_in activity.
    logic [CountW-1:0] count_q = '0;
    logic              reset_out_q = 1'b1;
    logic [CountW-1:0] count_d;
    logic              reset_out_d;

    // Next state: count up to LENGTH and saturate; release on the LENGTH-1 -> LENGTH edge.
    always_comb begin
        count_d     = count_q;
        reset_out_d = reset_out_q;
        if (count_q < CountMax) begin
            count_d = count_q + CountW'(1);
            if (count_q == CountLast) begin
                reset_out_d = 1'b0;
            end
        end
    end

    // State register; a low reset_in wins over any clock edge and restarts the stretch.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            count_q     <= '0;
            reset_out_q <= 1'b1;
        end else begin
            count_q     <= count_d;
            reset_out_q <= reset_out_d;
        end
    end

    assign bus.reset_out = reset_out_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_sync_reset_timer.sv
// Scoreboard bench for sync_reset_timer: a LENGTH=7 and a LENGTH=1 instance, sampled on falling
// clock edges or just after an asynchronous reset_in fall.
`timescale 1ns / 100ps
module tb_sync_reset_timer;
    typedef struct {
        string name;
        bit    dut_b;
        logic  exp_out;
        int    exp_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    exp_t exp_q[$];
    event sample_ev;
    int   n_tests = 0;
    int   n_fail = 0;

    sync_reset_timer_if #(.LENGTH(7)) bus_a ();
    sync_reset_timer_if #(.LENGTH(1)) bus_b ();

    sync_reset_timer #(.LENGTH(7)) u_dut_a (
        .clk      (clk),
        .reset_in (rst_a),
        .bus      (bus_a.master)
    );

    sync_reset_timer #(.LENGTH(1)) u_dut_b (
        .clk      (clk),
        .reset_in (rst_b),
        .bus      (bus_b.master)
    );

    // 2 ns period, rising edges at 1, 3, 5 ...
    always #1 clk = ~clk;

    // Monitor: pop the oldest expectation and compare whenever a sample is presented
    always @(sample_ev) begin
        exp_t e;
        logic act_out;
        int   act_cnt;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_underflow at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            act_out = e.dut_b ? bus_b.reset_out : bus_a.reset_out;
            act_cnt = e.dut_b ? int'(bus_b.count) : int'(bus_a.count);
            n_tests++;
            if (act_out !== e.exp_out || act_cnt != e.exp_cnt) begin
                n_fail++;
                $display("FAIL %s at %0t: reset_out=%b count=%0d, expected reset_out=%b count=%0d",
                         e.name, $time, act_out, act_cnt, e.exp_out, e.exp_cnt);
            end
        end
    end

    task automatic chk(input string name, input bit dut_b, input logic eo, input int ec);
        exp_t e;
        e.name = name;
        e.dut_b = dut_b;
        e.exp_out = eo;
        e.exp_cnt = ec;
        exp_q.push_back(e);
        -> sample_ev;
        #0;
    endtask

    // After release of instance A: high for 6 edges, low from edge 7, count saturates at 7
    task automatic run_release_a(input string name, input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            chk(name, 1'b0, (i < 7) ? 1'b1 : 1'b0, (i < 7) ? i : 7);
        end
    endtask

    initial begin
        #0.1;
        chk("powerup_t0_a", 1'b0, 1'b1, 0);
        chk("powerup_t0_b", 1'b1, 1'b1, 0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk("powerup_a", 1'b0, (i < 7) ? 1'b1 : 1'b0, (i < 7) ? i : 7);
            chk("powerup_b", 1'b1, 1'b0, 1);
        end

        // One-cycle pulse from idle
        rst_a = 1'b0;
        #0.1;
        chk("pulse_async_assert", 1'b0, 1'b1, 0);
        @(negedge clk);
        chk("pulse_held", 1'b0, 1'b1, 0);
        rst_a = 1'b1;
        run_release_a("pulse_release", 9);

        // Mid-count restart at count=4
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("mid_precount", 1'b0, 1'b1, i);
        end
        rst_a = 1'b0;
        #0.1;
        chk("mid_async_assert", 1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_held", 1'b0, 1'b1, 0);
        end
        rst_a = 1'b1;
        run_release_a("mid_release", 9);

        // Long hold of 20 cycles
        rst_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("long_held", 1'b0, 1'b1, 0);
        end
        rst_a = 1'b1;
        run_release_a("long_release", 9);

        // LENGTH=1 instance pulse
        rst_b = 1'b0;
        #0.1;
        chk("len1_async_assert", 1'b1, 1'b1, 0);
        @(negedge clk);
        chk("len1_held", 1'b1, 1'b1, 0);
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("len1_release", 1'b1, 1'b0, 1);
        end

        // Saturation: no wrap-around over a long idle stretch
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("saturate", 1'b0, 1'b0, 7);
        end

        #0.5;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
